// File: rtl/core_cfg_pkg.sv
// Shared types and sizing helpers for the CLB configuration loader.
package core_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CSUM,
    ST_CHECK,
    ST_COMMIT,
    ST_ERROR
  } state_t;

  localparam int DEF_NUM_ROWS = 8;
  localparam int DEF_ROW_BITS = 552;

  function automatic int calc_num_words(input int total_bits, input int word_w);
    return (total_bits + word_w - 1) / word_w;
  endfunction

  // MSB index of row r on the prog bus; row 0 sits at the top.
  function automatic int row_msb(input int total_bits, input int row_bits, input int row);
    return total_bits - 1 - row * row_bits;
  endfunction

endpackage

// File: rtl/prog_csum_acc.sv
// Modulo-2^WORD_W additive checksum accumulator with clear, enable and compare.
module prog_csum_acc #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [WORD_W-1:0] i_word,
  input  logic [WORD_W-1:0] i_expected,
  output logic              o_match
);

  logic [WORD_W-1:0] r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + i_word;
    end
  end

  assign o_match = (r_acc == i_expected);

endmodule

// File: rtl/core_prog_loader.sv
// Streams a configuration into a shadow register, verifies its checksum and commits it atomically to prog.
// Optional readback port of the active configuration: define CORE_PROG_READBACK_EN.
module core_prog_loader
  import core_cfg_pkg::*;
#(
  parameter int NUM_ROWS = DEF_NUM_ROWS,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int WORD_W   = 32
) (
  input  logic                         clb_clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [WORD_W-1:0]            s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [NUM_ROWS*ROW_BITS-1:0] prog,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         cfg_valid
`ifdef CORE_PROG_READBACK_EN
  ,
  input  logic [$clog2(NUM_ROWS)-1:0]  rb_row,
  output logic [ROW_BITS-1:0]          rb_data
`endif
);

  localparam int TOTAL_BITS = NUM_ROWS * ROW_BITS;
  localparam int NUM_WORDS  = calc_num_words(TOTAL_BITS, WORD_W);
  localparam int PAD_BITS   = NUM_WORDS * WORD_W;
  localparam int CNT_W      = $clog2(NUM_WORDS + 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [PAD_BITS-1:0]     r_shadow;
  logic [TOTAL_BITS-1:0]   r_prog;
  logic [WORD_W-1:0]       r_exp;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic                    r_cfg_valid;

  logic                    w_xfer;
  logic                    w_accept_start;
  logic                    w_match;

  assign w_xfer         = r_ready && s_valid && !abort;
  assign w_accept_start = (r_state == ST_IDLE) && start && !abort;

  prog_csum_acc #(
    .WORD_W (WORD_W)
  ) u_csum (
    .clk        (clb_clk),
    .rst        (rst),
    .i_clr      (w_accept_start),
    .i_en       (w_xfer && (r_state == ST_LOAD)),
    .i_word     (s_data),
    .i_expected (r_exp),
    .o_match    (w_match)
  );

  // Shadow is padded to whole words; any excess low bits of the last word never reach prog.
  always_ff @(posedge clb_clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_prog      <= '0;
      r_exp       <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_cfg_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept_start) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
              if (r_cnt == CNT_W'(k)) r_shadow[PAD_BITS-1-k*WORD_W -: WORD_W] <= s_data;
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(NUM_WORDS - 1)) r_state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            r_exp   <= s_data;
            r_state <= ST_CHECK;
            r_ready <= 1'b0;
          end
        end
        ST_CHECK: begin
          r_state <= w_match ? ST_COMMIT : ST_ERROR;
        end
        ST_COMMIT: begin
          r_prog      <= r_shadow[PAD_BITS-1 -: TOTAL_BITS];
          r_cfg_valid <= 1'b1;
          r_done      <= 1'b1;
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
        end
        ST_ERROR: begin
          r_err   <= 1'b1;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready   = r_ready;
  assign prog      = r_prog;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign cfg_valid = r_cfg_valid;

`ifdef CORE_PROG_READBACK_EN
  logic [ROW_BITS-1:0] r_rb_data;

  always_ff @(posedge clb_clk or posedge rst) begin
    if (rst) begin
      r_rb_data <= '0;
    end else begin
      r_rb_data <= '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (int'(rb_row) == r) r_rb_data <= r_prog[row_msb(TOTAL_BITS, ROW_BITS, r) -: ROW_BITS];
      end
    end
  end

  assign rb_data = r_rb_data;
`endif

endmodule
